// File: rtl/sqrt_iter.sv
// Iterative restoring integer square root: one root bit per enabled clock,
// producing floor(sqrt(radical)) and radical - q^2 behind valid/ready handshakes.
module sqrt_iter #(
  parameter int WIDTH   = 21,
  parameter int Q_WIDTH = (WIDTH + 1) / 2,
  parameter int R_WIDTH = Q_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   radical,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Q_WIDTH-1:0] q,
  output logic [R_WIDTH-1:0] remainder,
  output logic               busy
);

  // Handshakes: a transfer happens on a rising edge where ena, valid and ready
  // are all high; valid must be held until that edge, ready never depends on valid.

  localparam int RAD_W = 2 * Q_WIDTH;
  localparam int CNT_W = (Q_WIDTH > 1) ? $clog2(Q_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Q_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [RAD_W-1:0]   r_rad;
  logic [Q_WIDTH-1:0] r_root;
  logic [R_WIDTH-1:0] r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [Q_WIDTH-1:0] r_q;
  logic [R_WIDTH-1:0] r_remainder;

  logic               w_accept;
  logic               w_release;
  logic               w_last;
  logic [1:0]         w_pair;
  logic [R_WIDTH+1:0] w_cand;
  logic [R_WIDTH+1:0] w_sub;
  logic               w_fits;
  logic [R_WIDTH-1:0] w_rem_next;
  logic [Q_WIDTH-1:0] w_root_next;

  assign w_accept  = ena & in_valid & (r_state == S_IDLE);
  assign w_release = ena & out_ready & (r_state == S_DONE);
  assign w_last    = ena & (r_state == S_RUN) & (r_cnt == '0);

  // Restoring step: try subtracting {root, 01} from {rem, next radical pair}.
  assign w_pair      = r_rad[RAD_W-1 -: 2];
  assign w_cand      = {r_rem, w_pair};
  assign w_sub       = {{(R_WIDTH - Q_WIDTH){1'b0}}, r_root, 2'b01};
  assign w_fits      = (w_cand >= w_sub);
  assign w_rem_next  = R_WIDTH'(w_fits ? (w_cand - w_sub) : w_cand);
  assign w_root_next = (r_root << 1) | Q_WIDTH'(w_fits);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (w_release) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rad       <= '0;
      r_root      <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_q         <= '0;
      r_remainder <= '0;
    end else if (ena) begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rad  <= RAD_W'(radical);
        r_root <= '0;
        r_rem  <= '0;
        r_cnt  <= CNT_LAST;
      end else if (r_state == S_RUN) begin
        r_rad  <= r_rad << 2;
        r_root <= w_root_next;
        r_rem  <= w_rem_next;
        r_cnt  <= r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          r_q         <= w_root_next;
          r_remainder <= w_rem_next;
        end
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign q         = r_q;
  assign remainder = r_remainder;

endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: default 21-bit instance plus an 8-bit instance swept
// exhaustively, with a queue scoreboard checking results and latency.
module tb_sqrt_iter;

  localparam int W   = 21;
  localparam int QW  = 11;
  localparam int RW  = 12;
  localparam int EW  = QW + RW;
  localparam int W8  = 8;
  localparam int QW8 = 4;
  localparam int RW8 = 5;
  localparam int EW8 = QW8 + RW8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic ena;

  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  radical;
  logic [QW-1:0] q;
  logic [RW-1:0] remainder;

  logic           in_valid_8, in_ready_8, out_valid_8, out_ready_8, busy_8;
  logic [W8-1:0]  radical_8;
  logic [QW8-1:0] q_8;
  logic [RW8-1:0] remainder_8;

  sqrt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .radical   (radical),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .remainder (remainder),
    .busy      (busy)
  );

  sqrt_iter #(.WIDTH(W8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid_8),
    .in_ready  (in_ready_8),
    .radical   (radical_8),
    .out_valid (out_valid_8),
    .out_ready (out_ready_8),
    .q         (q_8),
    .remainder (remainder_8),
    .busy      (busy_8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;

  logic [EW-1:0]  exp_q[$];
  int             lat_q[$];
  int             acc_q[$];
  logic [EW8-1:0] exp8_q[$];
  int             acc8_q[$];
  bit             prev_ov  = 1'b0;
  bit             prev_ov8 = 1'b0;
  logic [EW-1:0]  mon_e;
  logic [EW8-1:0] mon_e8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Accept edge = cyc+1 seen from the negedge before it; latency = edges from accept to out_valid.
  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      acc8_q.delete();
      prev_ov  = 1'b0;
      prev_ov8 = 1'b0;
    end else begin
      if (ena && in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0 || lat_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(lat_q.pop_front()));
      end
      if (ena && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("q", 64'(q), 64'(mon_e[EW-1:RW]));
          chk("remainder", 64'(remainder), 64'(mon_e[RW-1:0]));
        end
      end
      prev_ov = out_valid;

      if (ena && in_valid_8 && in_ready_8) acc8_q.push_back(cyc + 1);
      if (out_valid_8 && !prev_ov8) begin
        if (acc8_q.size() == 0) chk("unexpected_out_valid_8", 1, 0);
        else chk("latency_8", 64'(cyc - acc8_q.pop_front()), 64'(4));
      end
      if (ena && out_valid_8 && out_ready_8) begin
        if (exp8_q.size() == 0) chk("unexpected_result_8", 1, 0);
        else begin
          mon_e8 = exp8_q.pop_front();
          chk("q_8", 64'(q_8), 64'(mon_e8[EW8-1:RW8]));
          chk("remainder_8", 64'(remainder_8), 64'(mon_e8[RW8-1:0]));
        end
      end
      prev_ov8 = out_valid_8;
    end
  end

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic send(input logic [W-1:0] rad, input logic [EW-1:0] exp, input int lat,
                      input bit track);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_wait_in_ready", 0, 1);
      return;
    end
    if (track) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
    end
    in_valid = 1'b1;
    radical  = rad;
    @(posedge clk); #1;
    in_valid = 1'b0;
    radical  = W'($urandom);
  endtask

  task automatic send8(input logic [W8-1:0] rad, input logic [EW8-1:0] exp);
    int n = 0;
    while (!in_ready_8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_8) begin
      chk("send8_wait_in_ready", 0, 1);
      return;
    end
    exp8_q.push_back(exp);
    in_valid_8 = 1'b1;
    radical_8  = rad;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    radical_8  = W8'($urandom);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0 || !in_ready || !in_ready_8) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(exp_q.size() == 0 && exp8_q.size() == 0 && in_ready && in_ready_8), 1);
  endtask

  typedef struct {
    logic [W-1:0]  rad;
    logic [QW-1:0] eq;
    logic [RW-1:0] er;
  } vec_t;

  typedef struct {
    logic [W8-1:0]  rad;
    logic [QW8-1:0] eq;
    logic [RW8-1:0] er;
  } vec8_t;

  vec_t  tbl[10];
  vec8_t tbl8[2];

  // ---------------- test sequence ----------------
  initial begin
    int r;
    int rnd;
    bit seen;

    tbl[0] = '{21'd3,       11'd1,    12'd2};
    tbl[1] = '{21'd0,       11'd0,    12'd0};
    tbl[2] = '{21'd1000003, 11'd1000, 12'd3};
    tbl[3] = '{21'd2097151, 11'd1448, 12'd447};
    tbl[4] = '{21'd1,       11'd1,    12'd0};
    tbl[5] = '{21'd15,      11'd3,    12'd6};
    tbl[6] = '{21'd16,      11'd4,    12'd0};
    tbl[7] = '{21'd1048576, 11'd1024, 12'd0};
    tbl[8] = '{21'd2097150, 11'd1448, 12'd446};
    tbl[9] = '{21'd1048575, 11'd1023, 12'd2046};
    tbl8[0] = '{8'd255, 4'd15, 5'd30};
    tbl8[1] = '{8'd200, 4'd14, 5'd4};

    rst = 1'b1; ena = 1'b1;
    in_valid = 1'b0; radical = '0; out_ready = 1'b1;
    in_valid_8 = 1'b0; radical_8 = '0; out_ready_8 = 1'b1;

    // Reset held for 3 edges with random inputs, including ena
    repeat (3) begin
      radical    = W'($urandom);
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = 1'($urandom_range(0, 1));
      radical_8  = W8'($urandom);
      in_valid_8 = 1'($urandom_range(0, 1));
      ena        = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rst = 1'b0; ena = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; in_valid_8 = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 1);
    chk("reset_out_valid", 64'(out_valid), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_q", 64'(q), 0);
    chk("reset_remainder", 64'(remainder), 0);
    chk("reset_in_ready_8", 64'(in_ready_8), 1);
    chk("reset_out_valid_8", 64'(out_valid_8), 0);

    // Table vectors, back to back with out_ready high
    for (int i = 0; i < 10; i++) send(tbl[i].rad, {tbl[i].eq, tbl[i].er}, 11, 1'b1);
    drain("drain_table");

    // Random radicals against the reference model
    for (int i = 0; i < 12; i++) begin
      rnd = int'($urandom_range(0, (1 << W) - 1));
      r   = isqrt(rnd);
      send(W'(rnd), {QW'(r), RW'(rnd - r * r)}, 11, 1'b1);
    end
    drain("drain_random");

    // Backpressure: result held while out_ready low
    out_ready = 1'b0;
    send(21'd144, {11'd12, 12'd0}, 11, 1'b1);
    for (int n = 0; n < 50 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("bp_out_valid_arrives", 64'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_q_hold", 64'(q), 12);
      chk("bp_rem_hold", 64'(remainder), 0);
      chk("bp_in_ready_low", 64'(in_ready), 0);
      chk("bp_out_valid_hold", 64'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_out_valid_released", 64'(out_valid), 0);
    chk("bp_in_ready_after", 64'(in_ready), 1);
    drain("drain_bp");

    // Enable stall of 4 cycles mid-run adds 4 cycles of latency
    send(21'd50, {11'd7, 12'd1}, 15, 1'b1);
    repeat (3) @(posedge clk);
    #1 ena = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("stall_busy_held", 64'(busy), 1);
    repeat (2) @(posedge clk);
    #1 ena = 1'b1;
    drain("drain_stall");

    // Reset mid-run discards the operation
    send(21'd99999, '0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_reset_in_ready", 64'(in_ready), 1);
    chk("mid_reset_busy", 64'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_reset_no_out_valid", 64'(seen), 0);
    send(21'd16, {11'd4, 12'd0}, 11, 1'b1);
    drain("drain_after_reset");

    // 8-bit instance: exhaustive sweep plus spot values
    for (int x = 0; x < 256; x++) begin
      r = isqrt(x);
      send8(W8'(x), {QW8'(r), RW8'(x - r * r)});
    end
    for (int i = 0; i < 2; i++) send8(tbl8[i].rad, {tbl8[i].eq, tbl8[i].er});
    drain("drain_w8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
